// File: rtl/pixel_pkg.sv
// Shared types for the pixel array readout path: pixel word type, shift FSM states
// and the one-hot row select decoder also used by the array controller.
package pixel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rd_state_e;

  // Index of the set bit; callers guarantee the input is one-hot.
  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pixel_row_fifo.sv
// Small synchronous FIFO of row words with a combinational head so the shift FSM
// can load the next row on the same edge it pops, avoiding a bubble between rows.
module pixel_row_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_readout_buffer.sv
// Captures one row word per row select during READ, buffers it and serialises it
// into a column-ordered pixel stream with valid/ready back-pressure.
module pixel_readout_buffer
  import pixel_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLUMNS    = 2,
  parameter int PIX_W      = pixel_pkg::PIX_W,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [ROWS-1:0]          read_array,
  input  logic [PIX_W*COLUMNS-1:0] data,
  input  logic                     clear,
  output logic [PIX_W-1:0]         pix_data,
  output logic [RW-1:0]            pix_row,
  output logic [CW-1:0]            pix_col,
  output logic                     pix_last,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     overflow,
  output logic                     sel_error
);

  localparam int WW = PIX_W * COLUMNS;
  localparam int FW = RW + WW;
  localparam logic [ROWS-1:0] SEL_ONE  = 1;
  localparam logic [CW-1:0]   COL_LAST = CW'(COLUMNS - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_ONE  = 1;

  logic [ROWS-1:0] prev_sel_q;
  logic [RW-1:0]   row_q;
  logic [WW-1:0]   word_q;
  logic [CW-1:0]   col_q;
  logic            valid_q;
  logic            overflow_q;
  logic            sel_error_q;
  rd_state_e       state_q;

  logic            sel_nonzero, sel_onehot, sel_multi;
  logic            push, pop, xfer, last_col;
  logic            fifo_full, fifo_empty;
  logic [RW-1:0]   cap_row;
  logic [FW-1:0]   fifo_din, fifo_dout;

  assign sel_nonzero = (read_array != '0);
  assign sel_onehot  = sel_nonzero && ((read_array & (read_array - SEL_ONE)) == '0);
  assign sel_multi   = read && sel_nonzero && !sel_onehot;
  assign cap_row     = RW'(onehot_to_idx(32'(read_array)));
  assign fifo_din    = {cap_row, data};

  // A held select is captured only on the cycle it first appears.
  assign push     = read && sel_onehot && (read_array != prev_sel_q) && !clear;
  assign last_col = (col_q == COL_LAST);
  assign xfer     = valid_q && pix_ready;
  assign pop      = !clear && !fifo_empty &&
                    ((state_q == IDLE) || (xfer && last_col));

  pixel_row_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sel_q  <= '0;
      row_q       <= '0;
      word_q      <= '0;
      col_q       <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      sel_error_q <= 1'b0;
      state_q     <= IDLE;
    end else if (clear) begin
      prev_sel_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      sel_error_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      prev_sel_q <= read ? read_array : '0;
      if (sel_multi) sel_error_q <= 1'b1;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            {row_q, word_q} <= fifo_dout;
            col_q           <= '0;
            valid_q         <= 1'b1;
            state_q         <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (!last_col) begin
              col_q <= col_q + COL_ONE;
            end else if (!fifo_empty) begin
              {row_q, word_q} <= fifo_dout;
              col_q           <= '0;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_data  = word_q[int'(col_q)*PIX_W +: PIX_W];
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_valid = valid_q;
  assign pix_last  = valid_q && (row_q == ROW_LAST) && last_col;
  assign overflow  = overflow_q;
  assign sel_error = sel_error_q;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Scoreboard bench: stimulus pushes expected pixels, a negedge monitor pops and
// compares on every transfer and checks that stalled outputs hold steady.
module tb_pixel_readout_buffer;
  import pixel_pkg::*;

  localparam int ROWS    = 2;
  localparam int COLUMNS = 2;
  localparam int PW      = 8;

  typedef struct {
    logic [PW-1:0] pix;
    logic          row;
    logic          col;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          read;
  logic [1:0]    read_array;
  logic [15:0]   data;
  logic          clear;
  logic [PW-1:0] pix_data;
  logic          pix_row;
  logic          pix_col;
  logic          pix_last;
  logic          pix_valid;
  logic          pix_ready;
  logic          overflow;
  logic          sel_error;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_mode = 1'b0;

  logic        prev_stall;
  logic [11:0] stall_snap;

  pixel_readout_buffer #(
    .ROWS       (ROWS),
    .COLUMNS    (COLUMNS),
    .PIX_W      (PW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .read_array (read_array),
    .data       (data),
    .clear      (clear),
    .pix_data   (pix_data),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_last   (pix_last),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .overflow   (overflow),
    .sel_error  (sel_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_row(input int row, input logic [15:0] word);
    exp_t e;
    for (int c = 0; c < COLUMNS; c++) begin
      e.pix  = word[c*PW +: PW];
      e.row  = row[0];
      e.col  = c[0];
      e.last = (row == ROWS - 1) && (c == COLUMNS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one row select for 'hold' cycles, then drop READ for one cycle.
  task automatic present_row(input int row, input logic [15:0] word, input int hold,
                             input bit expect_push);
    if (expect_push) exp_row(row, word);
    read       = 1'b1;
    read_array = 2'b01 << row;
    data       = word;
    repeat (hold) tick();
    read       = 1'b0;
    read_array = 2'b00;
    data       = 16'h0000;
    tick();
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, sb.size(), 0);
    repeat (3) tick();
    chk({name, "_idle"}, {31'd0, pix_valid}, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {20'd0, pix_valid, pix_data, pix_row, pix_col, pix_last},
            {20'd0, stall_snap});
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pixel", {23'd0, pix_valid, pix_data}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("pixel row=%0d col=%0d data=%h last=%0d", pix_row, pix_col, pix_data,
                   pix_last);
          chk("pix_data", {24'd0, pix_data}, {24'd0, e.pix});
          chk("pix_rowcol_last", {29'd0, pix_row, pix_col, pix_last},
              {29'd0, e.row, e.col, e.last});
        end
      end
      prev_stall = pix_valid && !pix_ready;
      stall_snap = {pix_valid, pix_data, pix_row, pix_col, pix_last};
    end
  end

  initial begin
    logic [15:0] t3 [6];
    logic [15:0] w;
    int          n;
    t3 = '{16'h1211, 16'h2221, 16'h3231, 16'h4241, 16'h5251, 16'h6261};

    reset = 1'b0; read = 1'b0; read_array = 2'b00; data = 16'h0; clear = 1'b0;
    pix_ready = 1'b0; prev_stall = 1'b0; stall_snap = '0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_flags", {30'd0, overflow, sel_error}, 0);
    chk("rst_pix", {22'd0, pix_data, pix_row, pix_col, pix_last}, 0);
    reset = 1'b1;
    tick();

    // Two rows, consumer always ready; checks first-word latency.
    pix_ready = 1'b1;
    exp_row(0, 16'h2211);
    read = 1'b1; read_array = 2'b01; data = 16'h2211;
    tick();
    chk("lat_edge_n", {31'd0, pix_valid}, 0);
    exp_row(1, 16'h4433);
    read_array = 2'b10; data = 16'h4433;
    tick();
    chk("lat_edge_n1", {31'd0, pix_valid}, 1);
    read = 1'b0; read_array = 2'b00; data = 16'h0;
    wait_drain("t1_drain", 40);

    // Held select captured once.
    present_row(0, 16'h6655, 5, 1'b1);
    wait_drain("t2_drain", 40);

    // Overflow with consumer stalled: row register plus four FIFO slots hold five rows.
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) present_row(k % 2, t3[k], 1, 1'b1);
    chk("t3_no_ovf_yet", {31'd0, overflow}, 0);
    present_row(1, t3[5], 1, 1'b0);
    chk("t3_ovf", {31'd0, overflow}, 1);
    pix_ready = 1'b1;
    wait_drain("t3_drain", 60);

    // Multi-hot select, then clear overriding a capture.
    read = 1'b1; read_array = 2'b11; data = 16'hDEAD;
    tick();
    chk("t4_sel_err", {30'd0, sel_error, overflow}, 32'd3);
    read_array = 2'b01; data = 16'h7877; clear = 1'b1;
    tick();
    chk("t4_cleared", {29'd0, sel_error, overflow, pix_valid}, 0);
    clear = 1'b0;
    exp_row(0, 16'h7877);
    tick();
    read = 1'b0; read_array = 2'b00; data = 16'h0;
    wait_drain("t4_drain", 40);

    // Random back-pressure over 64 frames.
    rand_mode = 1'b1;
    fork
      begin
        for (int f = 0; f < 64; f++) begin
          for (int r = 0; r < ROWS; r++) begin
            n = 0;
            while (sb.size() > 4 && n < 200) begin
              tick();
              n++;
            end
            if (n >= 200) chk("t5_wait_timeout", 32'd1, 32'd0);
            w = 16'($urandom);
            present_row(r, w, 1, 1'b1);
          end
        end
        rand_mode = 1'b0;
      end
      begin
        while (rand_mode) begin
          tick();
          pix_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    pix_ready = 1'b1;
    wait_drain("t5_drain", 200);
    chk("t5_no_ovf", {31'd0, overflow}, 0);

    // Reset mid-stream with two rows still buffered.
    pix_ready = 1'b0;
    present_row(0, 16'hC1C0, 1, 1'b0);
    present_row(1, 16'hC3C2, 1, 1'b0);
    present_row(0, 16'hC5C4, 1, 1'b0);
    chk("t6_pre_valid", {31'd0, pix_valid}, 1);
    #2 reset = 1'b0;
    #1 chk("t6_rst_async", {31'd0, pix_valid}, 0);
    #3 reset = 1'b1;
    pix_ready = 1'b1;
    repeat (6) tick();
    chk("t6_no_stale", {31'd0, pix_valid}, 0);
    present_row(1, 16'hBBAA, 1, 1'b1);
    wait_drain("t6_drain", 40);

    chk("sb_empty_end", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
